// File: rtl/vend_pkg.sv
// Shared types and price/coin tables for the vending-machine controller.
package vend_pkg;

    typedef enum logic [1:0] {
        SELECT,
        PAY,
        VEND,
        CHANGE
    } vend_state_e;

    localparam int unsigned ITEM_PRICE [0:7] = '{100, 120, 240, 300, 220, 195, 285, 55};
    // Index 0 is the largest denomination; greedy change relies on this ordering.
    localparam int unsigned COIN_VAL [0:3] = '{100, 25, 10, 5};

endpackage

// File: rtl/change_dispenser.sv
// Change register with greedy coin selection and a ready/valid dispense handshake.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned N_COINS  = 4,
    parameter int unsigned CREDIT_W = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [CREDIT_W-1:0] i_amount,
    input  logic                i_active,
    input  logic                i_chg_ready,
    output logic                o_chg_valid,
    output logic [N_COINS-1:0]  o_chg_coin,
    output logic                o_done,
    output logic [CREDIT_W-1:0] o_change
);

    logic [CREDIT_W-1:0] r_change;
    logic [N_COINS-1:0]  w_coin;
    logic [CREDIT_W-1:0] w_coin_val;
    logic                w_fit;

    // First (largest) denomination that still fits the remaining change.
    always_comb begin
        w_coin     = '0;
        w_coin_val = '0;
        w_fit      = 1'b0;
        for (int i = 0; i < N_COINS; i++) begin
            if (!w_fit && (CREDIT_W'(COIN_VAL[i]) <= r_change)) begin
                w_fit      = 1'b1;
                w_coin[i]  = 1'b1;
                w_coin_val = CREDIT_W'(COIN_VAL[i]);
            end
        end
    end

    assign o_chg_valid = i_active && w_fit;
    assign o_chg_coin  = o_chg_valid ? w_coin : '0;
    assign o_done      = i_active && !w_fit;
    assign o_change    = r_change;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_change <= '0;
        end else if (i_load) begin
            r_change <= i_amount;
        end else if (o_chg_valid && i_chg_ready) begin
            r_change <= r_change - w_coin_val;
        end else if (o_done) begin
            // Any remainder below the smallest coin is dropped.
            r_change <= '0;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction core: credit tracking, vend strobe, blink timer and change return.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned N_ITEMS   = 8,
    parameter int unsigned N_COINS   = 4,
    parameter int unsigned CREDIT_W  = 11,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_ITEMS-1:0]  sel,
    input  logic [N_COINS-1:0]  coin_in,
    input  logic                card,
    input  logic                cancel,
    input  logic                chg_ready,
    output logic                chg_valid,
    output logic [N_COINS-1:0]  chg_coin,
    output logic                vend_pulse,
    output logic [CREDIT_W-1:0] due,
    output logic [CREDIT_W-1:0] credit,
    output logic                select_led,
    output logic                payment_led,
    output logic                vend_led,
    output logic                blink
);

    localparam int unsigned SUM_W   = CREDIT_W + 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};

    vend_state_e         r_state;
    vend_state_e         w_state_d;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_d;
    logic [CREDIT_W-1:0] r_due;
    logic [CREDIT_W-1:0] w_due_d;
    logic                r_vend_pulse;
    logic                r_blink;
    logic [BLINK_W-1:0]  r_blink_cnt;

    logic [CREDIT_W-1:0] w_price;
    logic [SUM_W-1:0]    w_coin_sum;
    logic [SUM_W-1:0]    w_credit_raw;
    logic [CREDIT_W-1:0] w_credit_sum;
    logic                w_sel_any;
    logic                w_vend_entry;

    logic                w_load;
    logic [CREDIT_W-1:0] w_amount;
    logic                w_done;
    logic [CREDIT_W-1:0] w_change;

    always_comb begin
        w_price = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel[i]) begin
                w_price = w_price + CREDIT_W'(ITEM_PRICE[i]);
            end
        end
    end

    always_comb begin
        w_coin_sum = '0;
        for (int i = 0; i < N_COINS; i++) begin
            if (coin_in[i]) begin
                w_coin_sum = w_coin_sum + SUM_W'(COIN_VAL[i]);
            end
        end
    end

    assign w_credit_raw = {1'b0, r_credit} + w_coin_sum;
    assign w_credit_sum = w_credit_raw[CREDIT_W] ? CREDIT_MAX : w_credit_raw[CREDIT_W-1:0];
    assign w_sel_any    = |sel;

    always_comb begin
        w_state_d  = r_state;
        w_credit_d = r_credit;
        w_load     = 1'b0;
        w_amount   = '0;
        unique case (r_state)
            SELECT: begin
                w_credit_d = '0;
                if (w_sel_any) begin
                    w_state_d = PAY;
                end
            end
            PAY: begin
                w_credit_d = w_credit_sum;
                if (cancel) begin
                    w_state_d  = CHANGE;
                    w_credit_d = '0;
                    w_load     = 1'b1;
                    w_amount   = w_credit_sum;
                end else if (card) begin
                    // Card pays in full; coins of the same cycle come back as change.
                    w_state_d = VEND;
                    w_load    = 1'b1;
                    w_amount  = w_credit_sum;
                end else if (!w_sel_any) begin
                    w_state_d  = (w_credit_sum != '0) ? CHANGE : SELECT;
                    w_credit_d = '0;
                    w_load     = 1'b1;
                    w_amount   = w_credit_sum;
                end else if (w_credit_sum >= w_price) begin
                    w_state_d = VEND;
                    w_load    = 1'b1;
                    w_amount  = w_credit_sum - w_price;
                end
            end
            VEND: begin
                if (!w_sel_any) begin
                    w_state_d  = (w_change != '0) ? CHANGE : SELECT;
                    w_credit_d = '0;
                end
            end
            CHANGE: begin
                w_credit_d = '0;
                if (w_done) begin
                    w_state_d = SELECT;
                end
            end
            default: begin
                w_state_d  = SELECT;
                w_credit_d = '0;
            end
        endcase
    end

    assign w_due_d      = (w_price > w_credit_d) ? (w_price - w_credit_d) : '0;
    assign w_vend_entry = (w_state_d == VEND) && (r_state != VEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SELECT;
            r_credit     <= '0;
            r_due        <= '0;
            r_vend_pulse <= 1'b0;
            r_blink      <= 1'b1;
            r_blink_cnt  <= '0;
        end else begin
            r_state      <= w_state_d;
            r_credit     <= w_credit_d;
            r_due        <= w_due_d;
            r_vend_pulse <= w_vend_entry;
            if ((w_state_d != VEND) || w_vend_entry) begin
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == BLINK_LAST) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    change_dispenser #(
        .N_COINS  (N_COINS),
        .CREDIT_W (CREDIT_W)
    ) u_change_dispenser (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_amount    (w_amount),
        .i_active    (r_state == CHANGE),
        .i_chg_ready (chg_ready),
        .o_chg_valid (chg_valid),
        .o_chg_coin  (chg_coin),
        .o_done      (w_done),
        .o_change    (w_change)
    );

    assign credit      = r_credit;
    assign due         = r_due;
    assign vend_pulse  = r_vend_pulse;
    assign blink       = r_blink;
    assign select_led  = (r_state == SELECT);
    assign payment_led = (r_state == PAY);
    assign vend_led    = (r_state == VEND);

endmodule
